flags_exec_sequencer: RTL

Two-phase instruction sequencer and status-register controller for the SPAM-1 CPU. It alternates the CPU between fetch and execute phases and owns the 8-bit active-low `czonENGL` status register. It evaluates the instruction's 4-bit condition against the registered flags to produce `_do_exec`. It loads ALU flags only at the end of an executed instruction that requests it. It sits between the control decoder (condition, `_set_flags`), the ALU (flag outputs) and the PC (advance strobe), and replaces ad-hoc gated flag clocking with a synchronous load enable.

---
 rtl/seq_pkg.sv | 64 ++++++
 rtl/cond_eval.sv | 39 +++
 rtl/flags_exec_sequencer.sv | 88 ++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the SPAM-1 fetch/execute sequencer.
// Status flags are active-low, packed as czonENGL with c in the MSB.
package seq_pkg;

  localparam int NFLAGS = 8;
  localparam int COND_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

  localparam logic [COND_W-1:0] COND_A     = 4'd0;
  localparam logic [COND_W-1:0] COND_C     = 4'd1;
  localparam logic [COND_W-1:0] COND_Z     = 4'd2;
  localparam logic [COND_W-1:0] COND_O     = 4'd3;
  localparam logic [COND_W-1:0] COND_N     = 4'd4;
  localparam logic [COND_W-1:0] COND_EQ    = 4'd5;
  localparam logic [COND_W-1:0] COND_NE    = 4'd6;
  localparam logic [COND_W-1:0] COND_GT    = 4'd7;
  localparam logic [COND_W-1:0] COND_LT    = 4'd8;
  localparam logic [COND_W-1:0] COND_NC    = 4'd9;
  localparam logic [COND_W-1:0] COND_NZ    = 4'd10;
  localparam logic [COND_W-1:0] COND_NO    = 4'd11;
  localparam logic [COND_W-1:0] COND_NN    = 4'd12;
  localparam logic [COND_W-1:0] COND_DI    = 4'd13;
  localparam logic [COND_W-1:0] COND_DO    = 4'd14;
  localparam logic [COND_W-1:0] COND_NEVER = 4'd15;

  // Bit positions within czonENGL (E/N/G/L are the comparator equal/not-equal/greater/less flags)
  localparam int FLAG_C  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_O  = 5;
  localparam int FLAG_N  = 4;
  localparam int FLAG_EQ = 3;
  localparam int FLAG_NE = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  function automatic logic [31:0] condName(input logic [COND_W-1:0] cond);
    logic [31:0] name;
    case (cond)
      COND_A:  name = "A   ";
      COND_C:  name = "C   ";
      COND_Z:  name = "Z   ";
      COND_O:  name = "O   ";
      COND_N:  name = "N   ";
      COND_EQ: name = "EQ  ";
      COND_NE: name = "NE  ";
      COND_GT: name = "GT  ";
      COND_LT: name = "LT  ";
      COND_NC: name = "NC  ";
      COND_NZ: name = "NZ  ";
      COND_NO: name = "NO  ";
      COND_NN: name = "NN  ";
      COND_DI: name = "DI  ";
      COND_DO: name = "DO  ";
      default: name = "NEVR";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: maps a condition code and the
// active-low status/UART flags to an active-low "condition true".
module cond_eval
  import seq_pkg::*;
(
  input  logic [COND_W-1:0] condition,
  input  logic [NFLAGS-1:0] flags_czonENGL,
  input  logic              _flag_di,
  input  logic              _flag_do,
  output logic              _cond_true
);

  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (condition)
      COND_A:     cond_true = 1'b1;
      COND_C:     cond_true = ~flags_czonENGL[FLAG_C];
      COND_Z:     cond_true = ~flags_czonENGL[FLAG_Z];
      COND_O:     cond_true = ~flags_czonENGL[FLAG_O];
      COND_N:     cond_true = ~flags_czonENGL[FLAG_N];
      COND_EQ:    cond_true = ~flags_czonENGL[FLAG_EQ];
      COND_NE:    cond_true = ~flags_czonENGL[FLAG_NE];
      COND_GT:    cond_true = ~flags_czonENGL[FLAG_GT];
      COND_LT:    cond_true = ~flags_czonENGL[FLAG_LT];
      COND_NC:    cond_true = flags_czonENGL[FLAG_C];
      COND_NZ:    cond_true = flags_czonENGL[FLAG_Z];
      COND_NO:    cond_true = flags_czonENGL[FLAG_O];
      COND_NN:    cond_true = flags_czonENGL[FLAG_N];
      COND_DI:    cond_true = ~_flag_di;
      COND_DO:    cond_true = ~_flag_do;
      default:    cond_true = 1'b0;
    endcase
  end

  assign _cond_true = ~cond_true;

endmodule

// File: rtl/flags_exec_sequencer.sv
// Two-phase FETCH/EXEC sequencer owning the active-low czonENGL status register.
// Define SEQ_HOLD_EN to expose the 'hold' stall input; otherwise hold is tied low.
module flags_exec_sequencer
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] condition,
  input  logic              _set_flags,
  input  logic [NFLAGS-1:0] alu_flags_czonENGL,
  input  logic              _flag_di,
  input  logic              _flag_do,
`ifdef SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic              phase_fetch,
  output logic              phase_exec,
  output logic              _do_exec,
  output logic [NFLAGS-1:0] flags_czonENGL,
  output logic              flags_load,
  output logic              pc_inc
);

`ifndef SEQ_HOLD_EN
  logic hold;
  assign hold = 1'b0;
`endif

  seq_state_e        state_q, state_d;
  logic              _do_exec_q, _do_exec_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              _cond_true;

  // Condition sees only the registered flags, so instruction N's load is visible to N+1
  cond_eval u_cond_eval (
    .condition      (condition),
    .flags_czonENGL (flags_q),
    ._flag_di       (_flag_di),
    ._flag_do       (_flag_do),
    ._cond_true     (_cond_true)
  );

  always_comb begin
    state_d    = state_q;
    _do_exec_d = _do_exec_q;
    flags_d    = flags_q;
    flags_load = (state_q == ST_EXEC) & ~_do_exec_q & ~_set_flags & ~hold;
    pc_inc     = (state_q == ST_EXEC) & ~hold;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!hold) begin
          state_d    = ST_EXEC;
          _do_exec_d = _cond_true;
        end
      end
      ST_EXEC: begin
        if (!hold) begin
          state_d    = ST_FETCH;
          _do_exec_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        _do_exec_d = 1'b1;
      end
    endcase
    if (flags_load) flags_d = alu_flags_czonENGL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      _do_exec_q <= 1'b1;
      flags_q    <= '1;
    end else begin
      state_q    <= state_d;
      _do_exec_q <= _do_exec_d;
      flags_q    <= flags_d;
    end
  end

  assign phase_fetch    = (state_q == ST_FETCH);
  assign phase_exec     = (state_q == ST_EXEC);
  assign _do_exec       = _do_exec_q;
  assign flags_czonENGL = flags_q;

endmodule
